// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch front end feeding the decode stage. It walks a
// sequential fetch PC out on the instruction-memory read port, captures each
// returned word together with the PC that produced it into a small FIFO, and
// presents the FIFO head to decode through a valid/ready handshake. A
// redirect flushes both the queue and the fetch in flight and restarts
// fetch at the new PC.
//
// Optional feature macro: FETCHQ_BYPASS_EN
//   When defined, a word returning into an empty queue is presented to decode
//   in the same cycle it arrives. If decode accepts it, the word is never
//   written. Otherwise it is written normally. When the macro is undefined,
//   every returned word is written first and becomes visible the next cycle.
//
// Parameters
//   DEPTH        queue entries (power of two, >= 2)
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset, clears all state
//   redirect     in   flush queue and in-flight fetch, restart at redirect_pc
//   redirect_pc  in   restart byte address (bit 0 ignored)
//   mem_raddr    out  instruction memory word address (fetch_pc[15:1])
//   mem_rdata    in   instruction word, valid one cycle after the address
//   out_valid    out  head entry available to decode
//   out_ready    in   decode accepts the head entry this cycle
//   out_pc       out  PC of the head entry
//   out_instr    out  instruction word of the head entry
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [14:0] mem_raddr,
    input  logic [15:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_pc,
    output logic [15:0] out_instr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [15:0]      fetch_pc_q,    fetch_pc_d;
    logic             inflight_q,    inflight_d;
    logic [15:0]      inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0] head_q,        head_d;
    logic [PTR_W-1:0] tail_q,        tail_d;
    logic [CNT_W-1:0] count_q,       count_d;

    logic [15:0]      pc_mem    [DEPTH];
    logic [15:0]      instr_mem [DEPTH];

    // -----------------------------------------------------------------------
    // Control decode
    // -----------------------------------------------------------------------
    logic queue_valid;
    logic credit_ok;
    logic issue;
    logic capture;
    logic bypass_hit;
    logic push;
    logic pop;

    always_comb begin
        queue_valid = (count_q != '0);

        // Credit counts the fetch in flight as an occupied slot, and ignores
        // any pop happening this cycle, so a returning word always has room.
        credit_ok = ((count_q + CNT_W'(inflight_q)) < DEPTH_CNT);
        issue     = !redirect && credit_ok;

        // Data for the in-flight fetch is on mem_rdata this cycle; a redirect
        // in the same cycle discards it.
        capture = inflight_q && !redirect;

`ifdef FETCHQ_BYPASS_EN
        bypass_hit = capture && !queue_valid;
`else
        bypass_hit = 1'b0;
`endif

        pop  = queue_valid && out_ready && !redirect;
        // A bypassed word that decode accepts this cycle never enters storage.
        push = capture && !(bypass_hit && out_ready);
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign mem_raddr = fetch_pc_q[15:1];

    always_comb begin
        out_valid = queue_valid || bypass_hit;
        if (bypass_hit) begin
            out_pc    = inflight_pc_q;
            out_instr = mem_rdata;
        end else begin
            out_pc    = pc_mem[head_q];
            out_instr = instr_mem[head_q];
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // through the block leaves one unassigned and infers a latch.
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;

        if (redirect) begin
            // Redirect overrides push, pop and issue in the same cycle.
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            inflight_d = 1'b0;
            fetch_pc_d = redirect_pc & 16'hFFFE;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase

            inflight_d = issue;
            if (issue) begin
                inflight_pc_d = fetch_pc_q;
                // Natural 16-bit wrap: 0xFFFE is followed by 0x0000.
                fetch_pc_d    = fetch_pc_q + 16'd2;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= 16'h0000;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 16'h0000;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its inputs.
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Entry storage
    // -----------------------------------------------------------------------
    // NOTE: the storage array has no reset. Entries are only read while count
    // marks them valid, so clearing them would add reset fan-out for nothing
    // and would prevent mapping onto RAM or plain flops without reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]    <= inflight_pc_q;
            instr_mem[tail_q] <= mem_rdata;
        end
    end

    // The credit rule makes a push into a full queue impossible.
    overflow_a : assert property (
        @(posedge clk) disable iff (reset) !(push && (count_q == DEPTH_CNT))
    );

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Drives fetch_queue with directed scenarios followed by a randomized phase.
// The reference model keeps the queue as an SV queue of PCs plus a single
// in-flight fetch, and independently tracks the PC that decode should accept
// next. The memory returns 0x1000 + word address one cycle after the
// address is presented.
// Build with +define+FETCHQ_BYPASS_EN to exercise the bypass variant.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int DEPTH = 4;
`ifdef FETCHQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int FIRST_LAT = BYP ? 1 : 2;
    localparam int REDIR_LAT = BYP ? 2 : 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [14:0] mem_raddr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_pc;
    logic [15:0] out_instr;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: word N holds 0x1000 + N.
    always @(posedge clk) mem_rdata <= 16'h1000 + {1'b0, mem_raddr};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] word_of(input logic [15:0] pc);
        return 16'h1000 + {1'b0, pc[15:1]};
    endfunction

    // Reference model state
    logic [15:0] m_q[$];
    bit          m_inf;
    logic [15:0] m_inf_pc;
    logic [15:0] m_fpc;
    logic [15:0] exp_next_pc;
    logic [15:0] acc_q[$];

    // Outputs observed in the most recent step
    logic        last_valid;
    logic [15:0] last_pc;
    logic [15:0] last_instr;

    task automatic model_reset();
        m_q.delete();
        m_inf       = 1'b0;
        m_inf_pc    = 16'h0000;
        m_fpc       = 16'h0000;
        exp_next_pc = 16'h0000;
        acc_q.delete();
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the
    // model with this cycle's inputs, then cross the rising edge.
    task automatic step(input logic r, input logic [15:0] rpc, input logic rdy);
        bit          byp_hit;
        bit          m_valid;
        bit          issue;
        logic [15:0] m_pc;
        redirect    = r;
        redirect_pc = rpc;
        out_ready   = rdy;
        @(negedge clk);
        byp_hit = BYP && m_inf && !r && (m_q.size() == 0);
        m_valid = (m_q.size() != 0) || byp_hit;
        m_pc    = byp_hit ? m_inf_pc : ((m_q.size() != 0) ? m_q[0] : 16'h0000);

        check("raddr", {17'h0, mem_raddr}, {17'h0, m_fpc[15:1]});
        check("valid", {31'h0, out_valid}, {31'h0, m_valid});
        if (m_valid && out_valid) begin
            check("pc", {16'h0, out_pc}, {16'h0, m_pc});
            check("instr", {16'h0, out_instr}, {16'h0, word_of(m_pc)});
        end
        last_valid = out_valid;
        last_pc    = out_pc;
        last_instr = out_instr;

        // Accepted stream must run consecutively from the last restart point.
        if (out_valid && rdy && !r) begin
            check("seq", {16'h0, out_pc}, {16'h0, exp_next_pc});
            acc_q.push_back(out_pc);
            exp_next_pc = exp_next_pc + 16'd2;
        end
        if (r) exp_next_pc = rpc & 16'hFFFE;

        if (r) begin
            m_q.delete();
            m_inf = 1'b0;
            m_fpc = rpc & 16'hFFFE;
        end else begin
            issue = (m_q.size() + int'(m_inf)) < DEPTH;
            if (m_valid && rdy && !byp_hit) void'(m_q.pop_front());
            if (m_inf && !(byp_hit && rdy)) m_q.push_back(m_inf_pc);
            m_inf = issue;
            if (issue) begin
                m_inf_pc = m_fpc;
                m_fpc    = m_fpc + 16'd2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Steps with out_ready high until out_valid is seen; checks cycle count.
    task automatic wait_valid(input string tag, input int exp_lat);
        int lat = 0;
        do begin
            step(1'b0, 16'h0000, 1'b1);
            lat++;
        end while (!last_valid && lat < 16);
        check(tag, lat, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_before;

        // Reset state and release latency
        do_reset();
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_raddr", {17'h0, mem_raddr}, 32'h0);
        step(1'b0, 16'h0000, 1'b1);
        wait_valid("t1_lat", FIRST_LAT);
        check("t1_pc0", {16'h0, last_pc}, 32'h0000);
        check("t1_in0", {16'h0, last_instr}, 32'h1000);
        step(1'b0, 16'h0000, 1'b1);
        check("t1_v1", {31'h0, last_valid}, 32'h1);
        check("t1_pc1", {16'h0, last_pc}, 32'h0002);
        check("t1_in1", {16'h0, last_instr}, 32'h1001);
        step(1'b0, 16'h0000, 1'b1);
        check("t1_v2", {31'h0, last_valid}, 32'h1);
        check("t1_pc2", {16'h0, last_pc}, 32'h0004);
        check("t1_in2", {16'h0, last_instr}, 32'h1002);

        // Stall: queue fills to DEPTH, issue stops, then drains in order
        do_reset();
        repeat (10) step(1'b0, 16'h0000, 1'b0);
        check("t2_full_valid", {31'h0, out_valid}, 32'h1);
        check("t2_head", {16'h0, out_pc}, 32'h0000);
        check("t2_raddr", {17'h0, mem_raddr}, 32'h0004);
        acc_q.delete();
        repeat (5) step(1'b0, 16'h0000, 1'b1);
        check("t2_ndrain", acc_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check("t2_drain", {16'h0, (i < acc_q.size()) ? acc_q[i] : 16'hDEAD}, 2 * i);
        end

        // Redirect with a valid head and out_ready high: head is not consumed
        check("t4_head_valid", {31'h0, last_valid}, 32'h1);
        n_before = acc_q.size();
        step(1'b1, 16'h0200, 1'b1);
        check("t4_no_pop", acc_q.size(), n_before);
        check("t4_empty", {31'h0, out_valid}, 32'h0);
        check("t4_raddr", {17'h0, mem_raddr}, 32'h0100);
        acc_q.delete();
        repeat (6) step(1'b0, 16'h0000, 1'b1);
        check("t4_first", {16'h0, (acc_q.size() > 0) ? acc_q[0] : 16'hDEAD}, 32'h0200);

        // Redirect with 3 queued entries and one fetch in flight
        do_reset();
        repeat (4) step(1'b0, 16'h0000, 1'b0);
        step(1'b1, 16'h0041, 1'b1);
        acc_q.delete();
        wait_valid("t3_lat", REDIR_LAT);
        check("t3_pc", {16'h0, last_pc}, 32'h0040);
        check("t3_instr", {16'h0, last_instr}, 32'h1020);

        // PC wrap through 0xFFFE
        step(1'b1, 16'hFFFC, 1'b1);
        acc_q.delete();
        repeat (8) step(1'b0, 16'h0000, 1'b1);
        check("t5_w0", {16'h0, (acc_q.size() > 0) ? acc_q[0] : 16'hDEAD}, 32'hFFFC);
        check("t5_w1", {16'h0, (acc_q.size() > 1) ? acc_q[1] : 16'hDEAD}, 32'hFFFE);
        check("t5_w2", {16'h0, (acc_q.size() > 2) ? acc_q[2] : 16'hDEAD}, 32'h0000);
        check("t5_w3", {16'h0, (acc_q.size() > 3) ? acc_q[3] : 16'hDEAD}, 32'h0002);

        // Asynchronous reset pulse between edges while the queue is full
        repeat (8) step(1'b0, 16'h0000, 1'b0);
        check("t6_full", {31'h0, out_valid}, 32'h1);
        #1 reset = 1'b1;
        #1;
        check("t6_valid", {31'h0, out_valid}, 32'h0);
        check("t6_raddr", {17'h0, mem_raddr}, 32'h0);
        reset = 1'b0;
        model_reset();
        step(1'b0, 16'h0000, 1'b1);
        wait_valid("t6_lat", FIRST_LAT);
        check("t6_pc", {16'h0, last_pc}, 32'h0000);

        // Randomized traffic: redirects, back-pressure bursts
        for (int c = 0; c < 3000; c++) begin
            logic r;
            logic rdy;
            r   = ($urandom_range(0, 19) == 0);
            rdy = ((c / 64) % 3 == 2) ? ($urandom_range(0, 7) == 0)
                                       : ($urandom_range(0, 3) != 0);
            step(r, 16'($urandom), rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end that sits directly upstream of the CPU decode/execute pipeline. It generates sequential fetch addresses on the instruction-memory read port (port 0), captures returned instruction words with their PCs into a small FIFO, and presents them to decode through a valid/ready handshake. A redirect (taken jump, store-to-code flush, load replay) flushes the queue and in-flight fetch and restarts at a new PC.

## Interface
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `redirect`  in  1  flush the queue and restart fetch at `redirect_pc`.
- `redirect_pc`  in  16  restart byte address; bit 0 ignored and forced to 0.
- `mem_raddr`  out  15  instruction memory word address (`fetch_pc[15:1]`).
- `mem_rdata`  in  16  instruction word; valid the cycle after the address was presented with issue.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  decode accepts head this cycle.
- `out_pc`  out  16  PC of head entry.
- `out_instr`  out  16  instruction word of head entry.

## Operation
- State:
  - `fetch_pc` (16b), reset 0x0000.
  - `inflight` (1b) plus `inflight_pc` (16b), reset 0.
  - Storage array of DEPTH {pc, instr}.
  - `head`/`tail` pointers, log2(DEPTH) bits, wrap mod DEPTH, reset 0.
  - `count` (0..DEPTH), reset 0.
- `mem_raddr = fetch_pc[15:1]` combinationally. Reset value is 0.
- Issue condition: `issue = !redirect && (count + inflight < DEPTH)`.
  - Credit check is conservative: a pop in the same cycle does not free a slot for that cycle's issue.
- On issue:
  - `inflight <= 1`, `inflight_pc <= fetch_pc`.
  - `fetch_pc <= fetch_pc + 2`, modulo 2^16, so 0xFFFE wraps to 0x0000.
- Without issue: `inflight <= 0`; `fetch_pc` holds.
- Capture: when `inflight` is 1 and there is no redirect, push {`inflight_pc`, `mem_rdata`} at `tail`.
- Pop: `out_valid && out_ready && !redirect` advances `head`.
  - Push and pop in the same cycle leave `count` unchanged.
- The credit rule guarantees a push never meets a full queue. An overflow is an assertion failure in simulation.
- `out_valid = (count != 0)`. `out_pc`/`out_instr` come from the head entry.
  - With count 0 they are don't-care; benches must not check them.
- Redirect has priority over everything in the same cycle:
  - `count`, `head`, `tail` cleared.
  - `inflight` cleared; the returning data is discarded.
  - Any same-cycle pop is ignored.
  - `fetch_pc <= {redirect_pc[15:1], 1'b0}`.
- A redirect held for multiple cycles keeps reloading `fetch_pc` and issues nothing.
- Reset asserted mid-operation clears all state immediately, regardless of the clock. The first issue occurs in the first cycle after deassertion, at PC 0x0000.

## Timing
- Redirect sampled at edge E0:
  - Cycle after E0: `mem_raddr = redirect_pc[15:1]`, issue.
  - Data returns the following cycle and is pushed at that edge.
  - Earliest `out_valid` is 3 cycles after the redirect cycle. With `FETCHQ_BYPASS_EN` it is 2.
- Steady state with `out_ready` held high: one instruction per cycle, consecutive PCs incrementing by 2.
- Stall: with `out_ready` low, issue stops once `count + inflight == DEPTH`. The queue holds DEPTH entries and `out_*` stay stable until accepted.

## Configuration
- `FETCHQ_BYPASS_EN` defined:
  - When `count == 0` and a capture occurs, `out_valid` is asserted the same cycle with `out_pc = inflight_pc` and `out_instr = mem_rdata`.
  - If `out_ready` is high, the word is consumed without being written.
  - If `out_ready` is low, the word is written normally.
- Undefined: captured data is always written first and becomes visible the next cycle.
- Both builds must pass the full test plan. Only the latency checks differ, by 1 cycle.

## Test plan
- Reset release, memory word at address N = 0x1000+N, `out_ready` = 1:
  - Outputs (0x0000, 0x1000), (0x0002, 0x1001), (0x0004, 0x1002) on consecutive cycles.
  - First valid output 2 cycles after reset release (1 with bypass).
- `out_ready` = 0 for 10 cycles after reset:
  - `count` saturates at 4 with PCs 0x0000..0x0006, and issue stops.
  - Releasing `out_ready` drains 0x0000..0x0006 in order, followed by 0x0008, with no gap or duplicate.
- Redirect to 0x0041 while 3 entries are queued and one fetch is in flight:
  - Next accepted output is PC 0x0040.
  - No stale entry is ever presented.
  - Latency is exactly 3 cycles (2 with bypass).
- Redirect asserted in the same cycle as `out_ready` with a valid head:
  - The head is not consumed; the queue becomes empty; fetch restarts at `redirect_pc`.
- Redirect to 0xFFFC with `out_ready` = 1:
  - Outputs are PCs 0xFFFC, 0xFFFE, 0x0000, 0x0002.
- `reset` pulsed mid-cycle, between edges, while the queue is full:
  - `out_valid` drops immediately and `mem_raddr` reads 0.
  - After release, fetch restarts at 0x0000.
